// File: rtl/render_sequencer_if.sv
// Bundles the frame-control and triangle-metering signals of render_sequencer.
//
// Handshake semantics: every *_in strobe (new_frame_in, src_done_in,
// issue_in, retire_in) is a single-cycle pulse sampled on the rising clock
// edge. issue_in is legal only in a cycle where issue_allow_out is high;
// retire_in is legal only while at least one triangle is in flight (or is
// being issued in the same cycle). Illegal strobes are dropped and latch
// proto_err_out. dbg_state / dbg_inflight expose the controller state.
interface render_sequencer_if #(
  parameter int CNT_W = 12,
  parameter int INF_W = 5
);
  logic             new_frame_in;
  logic             enable_in;
  logic             fetch_start_out;
  logic             src_done_in;
  logic             issue_in;
  logic             issue_allow_out;
  logic             retire_in;
  logic             obj_done_out;
  logic             busy_out;
  logic [CNT_W-1:0] tri_count_out;
  logic [7:0]       overrun_count_out;
  logic             proto_err_out;
  logic [1:0]       dbg_state;
  logic [INF_W-1:0] dbg_inflight;

  // Environment side: drives frame strobes and triangle traffic.
  modport master (
    output new_frame_in, enable_in, src_done_in, issue_in, retire_in,
    input  fetch_start_out, issue_allow_out, obj_done_out, busy_out,
           tri_count_out, overrun_count_out, proto_err_out,
           dbg_state, dbg_inflight
  );

  // Sequencer side.
  modport slave (
    input  new_frame_in, enable_in, src_done_in, issue_in, retire_in,
    output fetch_start_out, issue_allow_out, obj_done_out, busy_out,
           tri_count_out, overrun_count_out, proto_err_out,
           dbg_state, dbg_inflight
  );
endinterface

// File: rtl/render_sequencer.sv
// Per-frame render controller: starts the triangle source on a frame
// boundary, meters triangles with an in-flight credit count sized to the
// triangle FIFO, waits for every issued triangle to retire, then pulses
// obj_done and publishes the frame's triangle count.
module render_sequencer #(
  parameter int MAX_INFLIGHT = 16,
  parameter int CNT_W        = 12
) (
  input  logic             clk_in,
  input  logic             rst_in,
  render_sequencer_if.slave bus
);
  // The interface's dbg_inflight width must equal INF_W.
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [INF_W-1:0] MAX_CNT  = INF_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [INF_W-1:0] inflight;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] tri_count;
  logic [7:0]       overrun;
  logic             fetch_start;
  logic             obj_done;
  logic             busy;
  logic             proto_err;

  logic             allow;
  logic             issue_ok;
  logic             retire_ok;
  logic             strobe_bad;
  logic [INF_W-1:0] inflight_nxt;

  // Credit check and strobe qualification; allow depends on registers only.
  always_comb begin
    allow        = (state == S_FETCH) && (inflight < MAX_CNT);
    issue_ok     = bus.issue_in && allow;
    retire_ok    = bus.retire_in && (state != S_IDLE) &&
                   ((inflight != '0) || issue_ok);
    strobe_bad   = (bus.issue_in && !issue_ok) || (bus.retire_in && !retire_ok);
    inflight_nxt = inflight + {{(INF_W-1){1'b0}}, issue_ok}
                            - {{(INF_W-1){1'b0}}, retire_ok};
  end

  // Frame state machine with its counters and registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= S_IDLE;
      inflight    <= '0;
      issued      <= '0;
      tri_count   <= '0;
      overrun     <= '0;
      fetch_start <= 1'b0;
      obj_done    <= 1'b0;
      busy        <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      fetch_start <= 1'b0;
      obj_done    <= 1'b0;
      inflight    <= inflight_nxt;

      if (strobe_bad) proto_err <= 1'b1;

      // A frame boundary while a frame is still running is lost, not queued.
      if (bus.new_frame_in && (state != S_IDLE) && (overrun != 8'hFF))
        overrun <= overrun + 8'd1;

      if (issue_ok && (issued != CNT_MAX)) issued <= issued + 1'b1;

      case (state)
        S_IDLE: begin
          if (bus.new_frame_in && bus.enable_in) begin
            state       <= S_FETCH;
            fetch_start <= 1'b1;
            busy        <= 1'b1;
            inflight    <= '0;
            issued      <= '0;
          end
        end
        S_FETCH: begin
          // A same-cycle issue has already been counted above.
          if (bus.src_done_in) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (inflight == '0) begin
            state     <= S_DONE;
            obj_done  <= 1'b1;
            tri_count <= issued;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fetch_start_out   = fetch_start;
  assign bus.issue_allow_out   = allow;
  assign bus.obj_done_out      = obj_done;
  assign bus.busy_out          = busy;
  assign bus.tri_count_out     = tri_count;
  assign bus.overrun_count_out = overrun;
  assign bus.proto_err_out     = proto_err;
  assign bus.dbg_state         = state;
  assign bus.dbg_inflight      = inflight;
endmodule

// File: tb/tb_render_sequencer.sv
// Bench for render_sequencer: directed table, hand-written corner
// sequences and randomized traffic against a frame-level reference model.
module tb_render_sequencer;
  localparam int MAX_INFLIGHT = 16;
  localparam int CNT_W        = 12;
  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic clk;
  logic rst_n;

  render_sequencer_if #(.CNT_W(CNT_W), .INF_W(5)) bus ();

  render_sequencer #(.MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_W-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is tracked as "triangles issued" and "triangles retired" so far;
  // in-flight is simply their difference.
  int m_phase;
  int m_iss_acc;
  int m_ret_acc;
  int m_issued;
  int m_tri;
  int m_ovr;
  bit m_perr;
  bit m_fetch;
  bit m_obj;

  task automatic model_reset();
    m_phase = P_IDLE; m_iss_acc = 0; m_ret_acc = 0; m_issued = 0;
    m_tri = 0; m_ovr = 0; m_perr = 0; m_fetch = 0; m_obj = 0;
    exp_q.delete();
  endtask

  function automatic int m_infl();
    return m_iss_acc - m_ret_acc;
  endfunction

  function automatic bit m_allow();
    return (m_phase == P_FETCH) && (m_infl() < MAX_INFLIGHT);
  endfunction

  task automatic model_edge(input bit nf, input bit en, input bit sd,
                            input bit iss, input bit ret);
    int infl;
    bit iss_ok;
    bit ret_ok;
    infl   = m_infl();
    iss_ok = iss && m_allow();
    ret_ok = ret && (m_phase != P_IDLE) && (infl > 0 || iss_ok);
    if ((iss && !iss_ok) || (ret && !ret_ok)) m_perr = 1;
    if (nf && m_phase != P_IDLE && m_ovr < 255) m_ovr++;
    if (iss_ok) begin
      m_iss_acc++;
      if (m_issued < (1 << CNT_W) - 1) m_issued++;
    end
    if (ret_ok) m_ret_acc++;
    m_fetch = 0;
    m_obj   = 0;
    case (m_phase)
      P_IDLE: if (nf && en) begin
        m_phase = P_FETCH; m_fetch = 1;
        m_iss_acc = 0; m_ret_acc = 0; m_issued = 0;
      end
      P_FETCH: if (sd) m_phase = P_DRAIN;
      P_DRAIN: if (infl == 0) begin
        m_phase = P_DONE; m_obj = 1; m_tri = m_issued;
        exp_q.push_back(CNT_W'(m_issued));
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic check_model();
    chk("fetch_start", int'(bus.fetch_start_out), int'(m_fetch));
    chk("obj_done", int'(bus.obj_done_out), int'(m_obj));
    chk("busy", int'(bus.busy_out), int'(m_phase != P_IDLE));
    chk("issue_allow", int'(bus.issue_allow_out), int'(m_allow()));
    chk("tri_count", int'(bus.tri_count_out), m_tri);
    chk("overrun", int'(bus.overrun_count_out), m_ovr);
    chk("proto_err", int'(bus.proto_err_out), int'(m_perr));
    chk("inflight", int'(bus.dbg_inflight), m_infl());
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive at negedge, sample 1 ns after the rising edge.
  task automatic step(input bit nf, input bit en, input bit sd,
                      input bit iss, input bit ret);
    @(negedge clk);
    bus.new_frame_in = nf;
    bus.enable_in    = en;
    bus.src_done_in  = sd;
    bus.issue_in     = iss;
    bus.retire_in    = ret;
    @(posedge clk);
    #1;
    model_edge(nf, en, sd, iss, ret);
    check_model();
    if (bus.obj_done_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_obj_done: got 1 expected 0 at %0t", $time);
      end else begin
        chk("sb_tri", int'(bus.tri_count_out), int'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.new_frame_in = 0; bus.enable_in = 0; bus.src_done_in = 0;
    bus.issue_in     = 0; bus.retire_in = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_model();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit nf, en, sd, iss, ret;
    bit fetch, obj, busy, allow;
    int tri_cnt;
  } vec_t;

  vec_t vecs[12];

  // ---------------- main test ----------------
  initial begin
    int fetch_seen;
    int obj_seen;
    int obj_cycle;
    int ovr_base;

    //                nf en sd is rt  fs ob by al tri
    vecs[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0};  // disabled frame ignored
    vecs[1]  = '{1, 1, 0, 0, 0,  1, 0, 1, 1, 0};  // start
    vecs[2]  = '{0, 1, 1, 0, 0,  0, 0, 1, 0, 0};  // empty: DRAIN
    vecs[3]  = '{0, 1, 0, 0, 0,  0, 1, 1, 0, 0};  // DONE, count 0
    vecs[4]  = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 0};  // IDLE
    vecs[5]  = '{1, 1, 0, 0, 0,  1, 0, 1, 1, 0};  // start
    vecs[6]  = '{0, 1, 0, 1, 0,  0, 0, 1, 1, 0};  // issue 1
    vecs[7]  = '{0, 1, 1, 1, 0,  0, 0, 1, 0, 0};  // issue 2 with src_done
    vecs[8]  = '{0, 1, 0, 0, 1,  0, 0, 1, 0, 0};  // retire
    vecs[9]  = '{0, 1, 0, 0, 1,  0, 0, 1, 0, 0};  // retire -> 0
    vecs[10] = '{0, 1, 0, 0, 0,  0, 1, 1, 0, 2};  // DONE, count 2
    vecs[11] = '{0, 1, 0, 0, 0,  0, 0, 0, 0, 2};  // IDLE

    do_reset();
    chk("rst_state_idle", int'(bus.dbg_state), 0);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].nf, vecs[i].en, vecs[i].sd, vecs[i].iss, vecs[i].ret);
      chk($sformatf("vec%0d_fetch", i), int'(bus.fetch_start_out), int'(vecs[i].fetch));
      chk($sformatf("vec%0d_obj", i), int'(bus.obj_done_out), int'(vecs[i].obj));
      chk($sformatf("vec%0d_busy", i), int'(bus.busy_out), int'(vecs[i].busy));
      chk($sformatf("vec%0d_allow", i), int'(bus.issue_allow_out), int'(vecs[i].allow));
      chk($sformatf("vec%0d_tri", i), int'(bus.tri_count_out), vecs[i].tri_cnt);
      chk($sformatf("vec%0d_perr", i), int'(bus.proto_err_out), 0);
    end

    // Basic frame: 8 issues, each retired 3 cycles later.
    fetch_seen = -1; obj_seen = 0; obj_cycle = -1;
    for (int c = 0; c <= 16; c++) begin
      step(c == 0, 1, c == 9, (c >= 1 && c <= 8), (c >= 4 && c <= 11));
      if (bus.fetch_start_out) fetch_seen = c + 1;
      if (bus.obj_done_out) begin obj_seen++; obj_cycle = c + 1; end
    end
    chk("basic_fetch_cycle", fetch_seen, 1);
    chk("basic_obj_count", obj_seen, 1);
    chk("basic_obj_cycle", obj_cycle, 13);
    chk("basic_tri", int'(bus.tri_count_out), 8);
    chk("basic_perr", int'(bus.proto_err_out), 0);

    // Credit limit and simultaneous events.
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 1, 0);
    chk("credit_allow_15", int'(bus.issue_allow_out), 1);
    step(0, 1, 0, 1, 0);
    chk("credit_allow_16", int'(bus.issue_allow_out), 0);
    chk("credit_perr_before", int'(bus.proto_err_out), 0);
    step(0, 1, 0, 1, 0);
    chk("credit_perr_17", int'(bus.proto_err_out), 1);
    chk("credit_inflight_17", int'(bus.dbg_inflight), 16);
    step(0, 1, 0, 0, 1);
    chk("credit_allow_after_retire", int'(bus.issue_allow_out), 1);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 1);
    chk("simul_inflight_pre", int'(bus.dbg_inflight), 5);
    step(0, 1, 0, 1, 1);
    chk("simul_inflight_5", int'(bus.dbg_inflight), 5);
    step(0, 1, 1, 1, 0);
    chk("srcdone_issue_inflight", int'(bus.dbg_inflight), 6);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1);
    idle(4);
    chk("srcdone_issue_tri", int'(bus.tri_count_out), 18);

    // Overrun: boundaries every 10 cycles during a 40-cycle frame.
    do_reset();
    fetch_seen = 0;
    for (int c = 0; c < 40; c++) begin
      step((c % 10) == 0, 1, c == 36, 0, 0);
      if (bus.fetch_start_out) fetch_seen++;
    end
    chk("overrun_fetch_once", fetch_seen, 1);
    chk("overrun_count_3", int'(bus.overrun_count_out), 3);
    chk("overrun_idle_end", int'(bus.busy_out), 0);

    // Boundary landing exactly on DONE->IDLE counts as overrun, no start.
    ovr_base = int'(bus.overrun_count_out);
    step(1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("done_edge_overrun", int'(bus.overrun_count_out), ovr_base + 1);
    chk("done_edge_no_start", int'(bus.busy_out), 0);

    // Saturation at 255.
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 1, 0, 0, 0);
    chk("overrun_sat", int'(bus.overrun_count_out), 255);
    step(0, 1, 1, 0, 0);
    idle(3);

    // Disabled boundary, then empty frame: obj_done 3 cycles after boundary.
    do_reset();
    step(1, 0, 0, 0, 0);
    chk("disabled_no_fetch", int'(bus.fetch_start_out), 0);
    chk("disabled_idle", int'(bus.busy_out), 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("empty_obj_done", int'(bus.obj_done_out), 1);
    chk("empty_tri", int'(bus.tri_count_out), 0);
    idle(2);

    // Reset in the middle of DRAIN with 4 in flight.
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 0);
    chk("middrain_inflight", int'(bus.dbg_inflight), 4);
    rst_n = 1'b0;
    #1;
    chk("rst_async_busy", int'(bus.busy_out), 0);
    chk("rst_async_allow", int'(bus.issue_allow_out), 0);
    chk("rst_async_inflight", int'(bus.dbg_inflight), 0);
    chk("rst_async_state", int'(bus.dbg_state), 0);
    chk("rst_async_tri", int'(bus.tri_count_out), 0);
    do_reset();
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    idle(3);
    chk("post_rst_tri", int'(bus.tri_count_out), 2);
    chk("post_rst_perr", int'(bus.proto_err_out), 0);

    // Randomized traffic, mostly legal, with occasional protocol violations.
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      for (int i = 0; i < 1000; i++) begin
        bit nf, en, sd, iss, ret;
        nf  = ($urandom_range(0, 24) == 0);
        en  = ($urandom_range(0, 3) != 0);
        sd  = (m_phase == P_FETCH) ? ($urandom_range(0, 29) == 0)
                                   : ($urandom_range(0, 49) == 0);
        iss = m_allow() ? ($urandom_range(0, 1) == 1)
                        : (seg != 0 && $urandom_range(0, 59) == 0);
        ret = (m_infl() > 0) ? ($urandom_range(0, 2) == 0)
                             : (seg != 0 && $urandom_range(0, 79) == 0);
        step(nf, en, sd, iss, ret);
      end
      // Let any open frame complete so the scoreboard drains.
      step(0, 1, 1, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0, m_infl() > 0);
      chk("sb_queue_empty", exp_q.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
